// File: rtl/st7789_window_sched_if.sv
// Purpose : handshake bundle between a window-write client and the ST7789 window scheduler.
// Latency : none, wires only.
// Backpress: valid/ready on requests, pixels and bytes. abort/busy/done/err are status lines.
// Ports   : req_* (window request), pix_* (RGB565 stream), byte_* (to SPI serializer),
//           abort (cancel), busy/done/err (status). slave = scheduler side, master = client side.
interface st7789_window_sched_if #(
  parameter int C_x_bits = 8,
  parameter int C_y_bits = 8
);
  logic                req_valid;
  logic                req_ready;
  logic [C_x_bits-1:0] req_x0;
  logic [C_x_bits-1:0] req_x1;
  logic [C_y_bits-1:0] req_y0;
  logic [C_y_bits-1:0] req_y1;
  logic                pix_valid;
  logic                pix_ready;
  logic [15:0]         pix_data;
  logic                byte_valid;
  logic                byte_ready;
  logic [7:0]          byte_data;
  logic                byte_dc;
  logic                abort;
  logic                busy;
  logic                done;
  logic                err;

  modport slave (
    input  req_valid, req_x0, req_x1, req_y0, req_y1,
    input  pix_valid, pix_data, byte_ready, abort,
    output req_ready, pix_ready, byte_valid, byte_data, byte_dc,
    output busy, done, err
  );

  modport master (
    output req_valid, req_x0, req_x1, req_y0, req_y1,
    output pix_valid, pix_data, byte_ready, abort,
    input  req_ready, pix_ready, byte_valid, byte_data, byte_dc,
    input  busy, done, err
  );
endinterface

// File: rtl/st7789_window_sched.sv
// Purpose : turns a window request plus an RGB565 pixel stream into the ST7789 CASET/RASET/RAMWR
//           byte sequence (command bytes dc=0, parameters and pixels dc=1).
// Latency : first byte (0x2A) offered the cycle after acceptance; one byte per accepted cycle after.
// Backpress: byte_data/byte_dc held until byte_ready; pixels only pulled in PIX_LOAD.
// Ports   : clk, resetn (async active-low), bus (slave modport of st7789_window_sched_if).
module st7789_window_sched #(
  parameter int C_x_bits = 8,
  parameter int C_y_bits = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  st7789_window_sched_if.slave  bus
);
  localparam int CW = C_x_bits + C_y_bits + 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_HDR      = 3'd1;
  localparam logic [2:0] S_PIX_LOAD = 3'd2;
  localparam logic [2:0] S_PIX_HI   = 3'd3;
  localparam logic [2:0] S_PIX_LO   = 3'd4;

  logic [2:0]          state;
  logic [3:0]          hdr_idx;
  logic [C_x_bits-1:0] x0_q, x1_q;
  logic [C_y_bits-1:0] y0_q, y1_q;
  logic [15:0]         pix_q;
  logic [CW-1:0]       pix_cnt;
  logic                done_q, err_q;

  logic                bad_req, byte_fire;
  logic [C_x_bits:0]   x_span;
  logic [C_y_bits:0]   y_span;
  logic [CW:0]         area;
  logic [7:0]          hdr_byte;
  logic                hdr_dc;

  assign bad_req   = (bus.req_x1 < bus.req_x0) || (bus.req_y1 < bus.req_y0);
  assign byte_fire = bus.byte_valid && bus.byte_ready;

  // Spans carry one extra bit so a full-range window (2^N) does not wrap to zero.
  assign x_span = {1'b0, x1_q} - {1'b0, x0_q} + (C_x_bits+1)'(1);
  assign y_span = {1'b0, y1_q} - {1'b0, y0_q} + (C_y_bits+1)'(1);
  assign area   = (CW+1)'(x_span) * (CW+1)'(y_span);

  // CASET / RASET / RAMWR header, coordinates zero-extended into the low parameter byte.
  always_comb begin
    hdr_byte = 8'h00;
    hdr_dc   = 1'b1;
    case (hdr_idx)
      4'd0:    begin hdr_byte = 8'h2A; hdr_dc = 1'b0; end
      4'd2:    hdr_byte = 8'(x0_q);
      4'd4:    hdr_byte = 8'(x1_q);
      4'd5:    begin hdr_byte = 8'h2B; hdr_dc = 1'b0; end
      4'd7:    hdr_byte = 8'(y0_q);
      4'd9:    hdr_byte = 8'(y1_q);
      4'd10:   begin hdr_byte = 8'h2C; hdr_dc = 1'b0; end
      default: hdr_byte = 8'h00;
    endcase
  end

  // Outputs decode from state only, so reset forces them to idle values immediately.
  always_comb begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.byte_dc    = 1'b0;
    case (state)
      S_HDR:    begin bus.byte_valid = 1'b1; bus.byte_data = hdr_byte;    bus.byte_dc = hdr_dc; end
      S_PIX_HI: begin bus.byte_valid = 1'b1; bus.byte_data = pix_q[15:8]; bus.byte_dc = 1'b1;   end
      S_PIX_LO: begin bus.byte_valid = 1'b1; bus.byte_data = pix_q[7:0];  bus.byte_dc = 1'b1;   end
      default:  bus.byte_valid = 1'b0;
    endcase
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.pix_ready = (state == S_PIX_LOAD);
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      hdr_idx <= 4'd0;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      pix_q   <= 16'h0000;
      pix_cnt <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      // Abort wins over everything else; a byte that fires alongside it is simply the last one.
      if (bus.abort && state != S_IDLE) begin
        state   <= S_IDLE;
        hdr_idx <= 4'd0;
        pix_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.req_valid) begin
              x0_q <= bus.req_x0;
              x1_q <= bus.req_x1;
              y0_q <= bus.req_y0;
              y1_q <= bus.req_y1;
              if (bad_req) begin
                err_q <= 1'b1;
              end else begin
                hdr_idx <= 4'd0;
                state   <= S_HDR;
              end
            end
          end
          S_HDR: begin
            if (byte_fire) begin
              if (hdr_idx == 4'd10) begin
                pix_cnt <= area[CW-1:0];
                state   <= S_PIX_LOAD;
              end else begin
                hdr_idx <= hdr_idx + 4'd1;
              end
            end
          end
          S_PIX_LOAD: begin
            if (bus.pix_valid) begin
              pix_q <= bus.pix_data;
              state <= S_PIX_HI;
            end
          end
          S_PIX_HI: begin
            if (byte_fire) state <= S_PIX_LO;
          end
          S_PIX_LO: begin
            if (byte_fire) begin
              pix_cnt <= pix_cnt - CW'(1);
              if (pix_cnt == CW'(1)) begin
                done_q <= 1'b1;
                state  <= S_IDLE;
              end else begin
                state <= S_PIX_LOAD;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
